// File: rtl/hcm_access_sequencer_pkg.sv
// Shared constants, state encodings and hit-request type for the HCM access sequencer.
// Row/info widths and queue depth match the HCMPP block.
package hcm_access_sequencer_pkg;

    localparam int ROWINDEXBITS_HCM = 10;
    localparam int HITINFOBITS      = 16;
    localparam int QUEUESIZE        = 4;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RESET   = 3'd1;
    localparam logic [2:0] ST_FILL    = 3'd2;
    localparam logic [2:0] ST_DRAIN   = 3'd3;
    localparam logic [2:0] ST_READOUT = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    typedef struct packed {
        logic [ROWINDEXBITS_HCM-1:0] row;
        logic                        isNew;
        logic [HITINFOBITS-1:0]      info;
    } hitReq_t;

endpackage

// File: rtl/hcm_access_sequencer_inflight.sv
// Up/down occupancy counter for outstanding HCMPP requests, with full/empty flags.
// A pop while empty is ignored so late responses cannot underflow the count.
module hcm_inflight_counter #(
    parameter int QUEUESIZE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic empty
);
    localparam int W = $clog2(QUEUESIZE + 1);

    logic [W-1:0] count;
    logic         decEff;

    assign decEff = dec && (count != '0);
    assign full   = (count == W'(QUEUESIZE));
    assign empty  = (count == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && !decEff) begin
            count <= count + 1'b1;
        end else if (!inc && decEff) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/hcm_access_sequencer.sv
// Event sequencer in front of HCMPP: reset, hit fill, write drain, row readout.
// Optional HCMSEQ_READ_DURING_FILL_EN lets reads use idle issue slots during FILL/DRAIN.
//
// state   | meaning
// IDLE    | waiting for eventStart
// RESET   | one-cycle hcmReset pulse
// FILL    | accepting hits, issuing row writes
// DRAIN   | waiting for write path to go quiet
// READOUT | accepting readout requests, issuing row reads
// DONE    | one-cycle eventDone pulse
module hcm_access_sequencer #(
    parameter int ROWINDEXBITS_HCM = hcm_access_sequencer_pkg::ROWINDEXBITS_HCM,
    parameter int HITINFOBITS      = hcm_access_sequencer_pkg::HITINFOBITS,
    parameter int QUEUESIZE        = hcm_access_sequencer_pkg::QUEUESIZE,
    parameter int DRAIN_CYCLES     = 5,
    parameter int COUNTBITS        = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        eventStart,
    input  logic                        hitValid,
    output logic                        hitReady,
    input  logic [ROWINDEXBITS_HCM-1:0] hitRow,
    input  logic                        hitIsNew,
    input  logic [HITINFOBITS-1:0]      hitInfo,
    input  logic                        hitsDone,
    input  logic                        rdValid,
    output logic                        rdReady,
    input  logic [ROWINDEXBITS_HCM-1:0] rdRow,
    input  logic                        rdDone,
    output logic                        hcmReset,
    output logic                        hcmWriteRow,
    output logic                        hcmSSIDIsNew,
    output logic [ROWINDEXBITS_HCM-1:0] hcmRowToWrite,
    output logic [HITINFOBITS-1:0]      hcmHitInfo,
    output logic                        hcmReadRow,
    output logic [ROWINDEXBITS_HCM-1:0] hcmRowToRead,
    input  logic                        hcmNewOutput,
    output logic [2:0]                  state,
    output logic                        eventDone,
    output logic [COUNTBITS-1:0]        hitCount,
    output logic [COUNTBITS-1:0]        readCount
);
    import hcm_access_sequencer_pkg::*;

    localparam int DRAINW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

    logic              hitsDoneSeen;
    logic              rdDoneSeen;
    logic [DRAINW-1:0] drainCnt;
    hitReq_t           hitReq;
    logic              full;
    logic              empty;
    logic              hitFire;
    logic              rdFire;

    hcm_inflight_counter #(.QUEUESIZE(QUEUESIZE)) u_inflight (
        .clk   (clk),
        .reset (reset),
        .inc   (hitFire || rdFire),
        .dec   (hcmNewOutput),
        .full  (full),
        .empty (empty)
    );

    assign hitReady = (state == ST_FILL) && !full && !hitsDoneSeen;
`ifdef HCMSEQ_READ_DURING_FILL_EN
    // Writes win the slot: a valid hit blocks reads while filling.
    assign rdReady = !full && !rdDoneSeen &&
                     ((state == ST_READOUT) || (state == ST_DRAIN) ||
                      ((state == ST_FILL) && !hitValid));
`else
    assign rdReady = (state == ST_READOUT) && !full && !rdDoneSeen;
`endif
    assign hitFire = hitValid && hitReady;
    assign rdFire  = rdValid && rdReady;

    assign hcmReset      = (state == ST_RESET);
    assign eventDone     = (state == ST_DONE);
    assign hcmRowToWrite = hitReq.row;
    assign hcmSSIDIsNew  = hitReq.isNew;
    assign hcmHitInfo    = hitReq.info;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            hitsDoneSeen <= 1'b0;
            rdDoneSeen   <= 1'b0;
            drainCnt     <= '0;
            hitReq       <= '0;
            hcmWriteRow  <= 1'b0;
            hcmReadRow   <= 1'b0;
            hcmRowToRead <= '0;
            hitCount     <= '0;
            readCount    <= '0;
        end else begin
            hcmWriteRow <= hitFire;
            hcmReadRow  <= rdFire;
            if (hitFire) begin
                hitReq <= '{row: hitRow, isNew: hitIsNew, info: hitInfo};
                if (hitCount != '1) hitCount <= hitCount + 1'b1;
            end
            if (rdFire) begin
                hcmRowToRead <= rdRow;
                if (readCount != '1) readCount <= readCount + 1'b1;
            end
            if (state != ST_IDLE && rdDone) rdDoneSeen <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (eventStart) begin
                        state        <= ST_RESET;
                        hitCount     <= '0;
                        readCount    <= '0;
                        hitsDoneSeen <= 1'b0;
                        rdDoneSeen   <= 1'b0;
                    end
                end
                ST_RESET: begin
                    state <= ST_FILL;
                    if (hitsDone) hitsDoneSeen <= 1'b1;
                end
                ST_FILL: begin
                    if (hitsDone) hitsDoneSeen <= 1'b1;
                    if (hitsDone || hitsDoneSeen) begin
                        state    <= ST_DRAIN;
                        drainCnt <= DRAINW'(DRAIN_CYCLES);
                    end
                end
                ST_DRAIN: begin
                    // Quiet window restarts whenever anything is outstanding or returns.
                    if (!empty || hcmNewOutput) drainCnt <= DRAINW'(DRAIN_CYCLES);
                    else if (drainCnt == '0)   state    <= ST_READOUT;
                    else                       drainCnt <= drainCnt - 1'b1;
                end
                ST_READOUT: begin
                    if (rdDoneSeen && empty) state <= ST_DONE;
                end
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

endmodule
